// File: rtl/instr_decode_buffer_pkg.sv
// instr_decode_buffer_pkg: opcode constants, buffer states and MIPS field positions
package instr_decode_buffer_pkg;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam int OPCODE_LSB = 26;
   localparam int RS_LSB     = 21;
   localparam int RT_LSB     = 16;
   localparam int RD_LSB     = 11;
   localparam int SHAMT_LSB  = 6;
   localparam int FUNCT_LSB  = 0;
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} bufState_e;
   function automatic logic isZextOp(input logic [5:0] op);
      return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
   endfunction
endpackage

// File: rtl/instr_decode_buffer_field_split.sv
// instr_field_split: slices a 32-bit MIPS instruction word into its fields
module instr_field_split
   import instr_decode_buffer_pkg::*;
(
   input  logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  funct,
   output logic [15:0] imm16,
   output logic [25:0] jtarget
);
   assign opcode  = instr[OPCODE_LSB +: 6];
   assign rs      = instr[RS_LSB +: 5];
   assign rt      = instr[RT_LSB +: 5];
   assign rd      = instr[RD_LSB +: 5];
   assign shamt   = instr[SHAMT_LSB +: 5];
   assign funct   = instr[FUNCT_LSB +: 6];
   assign imm16   = instr[15:0];
   assign jtarget = instr[25:0];
endmodule

// File: rtl/instr_decode_buffer.sv
// instr_decode_buffer: two-entry fetch-to-decode skid FIFO with field split; DECODE_ZEXT_EN adds out_zext
module instr_decode_buffer
   import instr_decode_buffer_pkg::*;
#(
   parameter int          PC_W      = 32,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [5:0]      out_opcode,
   output logic [4:0]      out_rs,
   output logic [4:0]      out_rt,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_shamt,
   output logic [5:0]      out_funct,
   output logic [15:0]     out_imm16,
   output logic [25:0]     out_jtarget,
   output logic [PC_W-1:0] out_pc4
`ifdef DECODE_ZEXT_EN
   ,
   output logic            out_zext
`endif
);
   bufState_e state, nextState;
   logic [31:0] headInstr, tailInstr;
   logic [PC_W-1:0] headPc, tailPc;
   logic inXfer, outXfer, loadHead, loadTail, shiftUp, drain;
   assign in_ready  = (state != TWO);
   assign out_valid = (state != EMPTY);
   assign inXfer    = in_valid && in_ready;
   assign outXfer   = out_valid && out_ready;
   assign loadHead  = inXfer && (state == EMPTY || outXfer);
   assign loadTail  = inXfer && state == ONE && !outXfer;
   assign shiftUp   = outXfer && state == TWO;
   assign drain     = outXfer && state == ONE && !inXfer;
   always_comb begin
      nextState = state;
      nextState = flush ? EMPTY
                : (inXfer && !outXfer) ? ((state == EMPTY) ? ONE : TWO)
                : (outXfer && !inXfer) ? ((state == TWO) ? ONE : EMPTY)
                : state;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else state <= nextState;
   end
   // Head word reverts to NOP when emptied; head PC is kept so out_pc4 holds
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         headInstr <= NOP_INSTR;
         tailInstr <= NOP_INSTR;
         headPc    <= '0;
         tailPc    <= '0;
      end else if (flush) begin
         headInstr <= NOP_INSTR;
         tailInstr <= NOP_INSTR;
      end else begin
         if (loadHead) begin
            headInstr <= in_instr;
            headPc    <= in_pc;
         end else if (shiftUp) begin
            headInstr <= tailInstr;
            headPc    <= tailPc;
            tailInstr <= NOP_INSTR;
         end else if (drain) begin
            headInstr <= NOP_INSTR;
         end
         if (loadTail) begin
            tailInstr <= in_instr;
            tailPc    <= in_pc;
         end
      end
   end
   assign out_pc4 = headPc + PC_W'(4);
   instr_field_split fieldSplit (
      .instr(headInstr), .opcode(out_opcode), .rs(out_rs), .rt(out_rt), .rd(out_rd),
      .shamt(out_shamt), .funct(out_funct), .imm16(out_imm16), .jtarget(out_jtarget)
   );
`ifdef DECODE_ZEXT_EN
   assign out_zext = out_valid && isZextOp(out_opcode);
`endif
endmodule

// File: tb/tb_instr_decode_buffer.sv
// tb_instr_decode_buffer: directed and randomized checks against a queue model of the buffer
module tb_instr_decode_buffer;
   localparam int PC_W = 32;
   localparam logic [31:0] NOP = 32'h0000_0000;
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic [31:0] in_instr = '0;
   logic [PC_W-1:0] in_pc = '0;
   logic in_ready, out_valid;
   logic [5:0] out_opcode, out_funct;
   logic [4:0] out_rs, out_rt, out_rd, out_shamt;
   logic [15:0] out_imm16;
   logic [25:0] out_jtarget;
   logic [PC_W-1:0] out_pc4;
`ifdef DECODE_ZEXT_EN
   logic out_zext;
`endif
   instr_decode_buffer #(.PC_W(PC_W), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
      .out_shamt(out_shamt), .out_funct(out_funct), .out_imm16(out_imm16),
      .out_jtarget(out_jtarget), .out_pc4(out_pc4)
`ifdef DECODE_ZEXT_EN
      , .out_zext(out_zext)
`endif
   );
   always #5 clk = ~clk;
   typedef struct packed {logic [31:0] instr; logic [PC_W-1:0] pc;} entry_t;
   entry_t q[$];
   logic [PC_W-1:0] expPc4 = 32'd4;
   int checks = 0, errors = 0;
   // One clock of stimulus; the queue model follows the buffer's transfer rules
   task automatic run_cycle(input logic v, input logic [31:0] w, input logic [PC_W-1:0] p,
                            input logic r, input logic f);
      bit canIn, canOut;
      in_valid = v; in_instr = w; in_pc = p; out_ready = r; flush = f;
      canIn = q.size() < 2;
      canOut = q.size() > 0;
      @(posedge clk);
      if (f) q.delete();
      else begin
         if (canOut && r) void'(q.pop_front());
         if (canIn && v) q.push_back(entry_t'{w, p});
      end
      if (q.size() > 0) expPc4 = q[0].pc + 32'd4;
      #1;
      in_valid = 1'b0; flush = 1'b0;
   endtask
   task automatic test_reset();
      #1;
      checks += 4;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      if (out_pc4 !== 32'd4) begin errors++; $display("FAIL reset_pc4 got %h want 4", out_pc4); end
      if ({out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct} !== NOP) begin
         errors++; $display("FAIL reset_fields got %h want %h", {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct}, NOP);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic test_basic();
      run_cycle(1, 32'h2008_FFFF, 32'h0040_0000, 1, 0);
      checks += 5;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", out_valid); end
      if (out_opcode !== 6'h08) begin errors++; $display("FAIL basic_opcode got %h want 08", out_opcode); end
      if (out_rt !== 5'd8) begin errors++; $display("FAIL basic_rt got %0d want 8", out_rt); end
      if (out_imm16 !== 16'hFFFF) begin errors++; $display("FAIL basic_imm16 got %h want ffff", out_imm16); end
      if (out_pc4 !== 32'h0040_0004) begin errors++; $display("FAIL basic_pc4 got %h want 00400004", out_pc4); end
      run_cycle(0, 0, 0, 1, 0);
      checks += 3;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_valid got %b want 0", out_valid); end
      if (out_imm16 !== NOP[15:0]) begin errors++; $display("FAIL empty_imm16 got %h want nop", out_imm16); end
      if (out_pc4 !== 32'h0040_0004) begin errors++; $display("FAIL empty_pc4_hold got %h want 00400004", out_pc4); end
   endtask
   task automatic test_back_to_back();
      run_cycle(1, 32'h0000_0A01, 32'h100, 0, 0);
      run_cycle(1, 32'h0000_0B02, 32'h104, 0, 0);
      checks += 2;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b want 0", in_ready); end
      if (out_imm16 !== 16'h0A01) begin errors++; $display("FAIL b2b_head got %h want 0a01", out_imm16); end
      run_cycle(1, 32'h0000_0C03, 32'h108, 0, 0);
      checks += 2;
      if (out_imm16 !== 16'h0A01) begin errors++; $display("FAIL b2b_stall_head got %h want 0a01", out_imm16); end
      if (out_pc4 !== 32'h104) begin errors++; $display("FAIL b2b_stall_pc4 got %h want 104", out_pc4); end
      run_cycle(1, 32'h0000_0C03, 32'h108, 1, 0);
      checks += 2;
      if (out_imm16 !== 16'h0B02) begin errors++; $display("FAIL b2b_second got %h want 0b02", out_imm16); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_again got %b want 1", in_ready); end
      run_cycle(1, 32'h0000_0C03, 32'h108, 1, 0);
      checks += 2;
      if (out_imm16 !== 16'h0C03) begin errors++; $display("FAIL b2b_third got %h want 0c03", out_imm16); end
      if (out_pc4 !== 32'h10C) begin errors++; $display("FAIL b2b_third_pc4 got %h want 10c", out_pc4); end
      run_cycle(0, 0, 0, 1, 0);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b want 0", out_valid); end
   endtask
   task automatic test_simultaneous();
      run_cycle(1, 32'h1111_0001, 32'h200, 0, 0);
      run_cycle(1, 32'h2222_0002, 32'h204, 1, 0);
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL simul_valid got %b want 1", out_valid); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL simul_ready got %b want 1", in_ready); end
      if (out_imm16 !== 16'h0002) begin errors++; $display("FAIL simul_head got %h want 0002", out_imm16); end
      run_cycle(0, 0, 0, 1, 0);
   endtask
   task automatic test_flush();
      run_cycle(1, 32'h3333_1234, 32'h300, 0, 0);
      run_cycle(1, 32'h4444_5678, 32'h304, 0, 0);
      run_cycle(1, 32'h5555_9ABC, 32'h308, 0, 1);
      checks += 4;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", out_valid); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", in_ready); end
      if (out_opcode !== NOP[31:26]) begin errors++; $display("FAIL flush_opcode got %h want nop", out_opcode); end
      if (out_jtarget !== NOP[25:0]) begin errors++; $display("FAIL flush_jtarget got %h want nop", out_jtarget); end
   endtask
   task automatic test_wrap();
      run_cycle(1, 32'h0800_0010, 32'hFFFF_FFFC, 1, 0);
      checks += 2;
      if (out_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h want 0", out_pc4); end
      if (out_jtarget !== 26'h10) begin errors++; $display("FAIL wrap_jtarget got %h want 10", out_jtarget); end
      run_cycle(0, 0, 0, 1, 0);
   endtask
   task automatic test_reset_mid();
      run_cycle(1, 32'h6666_0066, 32'h400, 0, 0);
      #2 rst_n = 1'b0;
      q.delete();
      expPc4 = 32'd4;
      #1;
      checks += 2;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid); end
      if (out_pc4 !== 32'd4) begin errors++; $display("FAIL midrst_pc4 got %h want 4", out_pc4); end
      @(negedge clk);
      rst_n = 1'b1;
      run_cycle(1, 32'h7777_0077, 32'h500, 0, 0);
      checks++;
      if (out_imm16 !== 16'h0077) begin errors++; $display("FAIL midrst_first got %h want 0077", out_imm16); end
      run_cycle(0, 0, 0, 1, 0);
   endtask
`ifdef DECODE_ZEXT_EN
   task automatic test_zext();
      run_cycle(1, 32'h3421_00FF, 32'h600, 0, 0);
      checks++;
      if (out_zext !== 1'b1) begin errors++; $display("FAIL zext_ori got %b want 1", out_zext); end
      run_cycle(1, 32'h2021_00FF, 32'h604, 1, 0);
      checks++;
      if (out_zext !== 1'b0) begin errors++; $display("FAIL zext_addi got %b want 0", out_zext); end
      run_cycle(0, 0, 0, 1, 0);
   endtask
`endif
   task automatic test_random();
      logic [31:0] w, exp;
      for (int i = 0; i < 400; i++) begin
         w = $urandom;
         if ($urandom_range(0, 3) == 0) w[31:26] = 6'h0C + 6'($urandom_range(0, 2));
         run_cycle(1'($urandom_range(0, 1)), w, $urandom, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 15) == 0);
         exp = (q.size() > 0) ? q[0].instr : NOP;
         checks += 5;
         if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", i, out_valid, q.size() > 0); end
         if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready[%0d] got %b want %b", i, in_ready, q.size() < 2); end
         if ({out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct} !== exp) begin
            errors++; $display("FAIL rnd_fields[%0d] got %h want %h", i, {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct}, exp);
         end
         if ({out_imm16, out_jtarget} !== {exp[15:0], exp[25:0]}) begin
            errors++; $display("FAIL rnd_imm_jt[%0d] got %h/%h want %h/%h", i, out_imm16, out_jtarget, exp[15:0], exp[25:0]);
         end
         if (out_pc4 !== expPc4) begin errors++; $display("FAIL rnd_pc4[%0d] got %h want %h", i, out_pc4, expPc4); end
`ifdef DECODE_ZEXT_EN
         checks++;
         if (out_zext !== (q.size() > 0 && exp[31:26] inside {6'h0C, 6'h0D, 6'h0E})) begin
            errors++; $display("FAIL rnd_zext[%0d] got %b", i, out_zext);
         end
`endif
      end
   endtask
   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_simultaneous();
      test_flush();
      test_wrap();
      test_reset_mid();
`ifdef DECODE_ZEXT_EN
      test_zext();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
